// File: rtl/cpu_pkg.sv
// Shared fetch-side types and constants: reset vector, word size, FIFO entry
// layout and the fetch state encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
  localparam int          WORD_BYTES   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {S_RUN, S_FAULT} fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO with flush and occupancy count; used both as the
// instruction buffer and as the in-order PC queue for outstanding fetches.
module fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush wins over both ends; pop of an empty FIFO is ignored.
  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always @(posedge clk) begin
    if (rst_n) assert (!(do_push && full_o && !do_pop));
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches, buffers
// responses with their PCs and drops stale responses after a redirect.
// Optional misaligned-target fault state enabled by FETCH_ALIGN_CHECK_EN.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_VECTOR,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d;
  logic [CW-1:0] ififo_cnt, pcq_cnt;
  logic          ififo_empty, ififo_full, pcq_empty, pcq_full;
  logic [31:0]   pcq_head;
  logic [63:0]   ififo_head;
  fetch_entry_t  head_e, push_e;
  logic [CW:0]   inflight;
  logic          run, credit_ok, gnt_fire, discard, push, pop;

`ifdef FETCH_ALIGN_CHECK_EN
  fetch_state_t state_q, state_d;
  assign run       = (state_q == S_RUN);
  // An aligned redirect out of the fault clears the error in that same cycle.
  assign fetch_err = (state_q == S_FAULT) && !(redirect && pc_next[1:0] == 2'b00);
`else
  assign run       = 1'b1;
  assign fetch_err = 1'b0;
`endif

  // Requests in flight plus buffered words never exceed DEPTH, so a push
  // always finds room.
  assign inflight  = {1'b0, out_q} + {1'b0, ififo_cnt};
  assign credit_ok = (inflight < (CW+1)'(DEPTH));
  assign imem_req  = rst_n && run && !redirect && credit_ok;
  assign imem_addr = pc_q;
  assign gnt_fire  = imem_req && imem_gnt;

  assign discard = imem_rvalid && (redirect || drop_q != '0);
  assign push    = imem_rvalid && !discard;
  assign pop     = instr_valid && instr_ready && !redirect;

  assign push_e      = '{pc: pcq_head, instr: imem_rdata};
  assign head_e      = fetch_entry_t'(ififo_head);
  assign instr_valid = !ififo_empty;
  assign instr       = head_e.instr;
  assign instr_pc    = head_e.pc;

  always_comb begin
    out_d  = out_q + CW'(gnt_fire) - CW'(imem_rvalid);
    drop_d = drop_q;
    pc_d   = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
    state_d = state_q;
`endif
    if (redirect) begin
      // Everything still owed by memory after this cycle is stale.
      drop_d = out_d;
`ifdef FETCH_ALIGN_CHECK_EN
      pc_d    = pc_next;
      state_d = (pc_next[1:0] == 2'b00) ? S_RUN : S_FAULT;
`else
      pc_d = word_align(pc_next);
`endif
    end else begin
      if (imem_rvalid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (gnt_fire) pc_d = pc_q + 32'(WORD_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
`ifdef FETCH_ALIGN_CHECK_EN
      state_q <= S_RUN;
`endif
    end else begin
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
`ifdef FETCH_ALIGN_CHECK_EN
      state_q <= state_d;
`endif
    end
  end

  fetch_fifo #(.DEPTH(DEPTH), .W(64)) u_ififo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .wdata_i (push_e),
    .rdata_o (ififo_head),
    .count_o (ififo_cnt),
    .empty_o (ififo_empty),
    .full_o  (ififo_full)
  );

  // Never flushed: dropped responses still retire their PC slot.
  fetch_fifo #(.DEPTH(DEPTH), .W(32)) u_pcq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (gnt_fire),
    .pop_i   (imem_rvalid),
    .flush_i (1'b0),
    .wdata_i (pc_q),
    .rdata_o (pcq_head),
    .count_o (pcq_cnt),
    .empty_o (pcq_empty),
    .full_o  (pcq_full)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rvalid && pcq_empty));
      assert (!(gnt_fire && pcq_full));
      assert (pcq_cnt == out_q);
      assert (!(push && ififo_full && !pop));
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit with a single-cycle memory model.
module tb_fetch_pc_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] pc_next = '0;
  logic        imem_req, imem_gnt = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        fetch_err;

  fetch_pc_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  fetch_entry_t exp_q[$];
  logic [31:0]  pend[$];
  logic [31:0]  glog[$];
  int           nchk = 0, nerr = 0, npop = 0;
  bit           mem_hold = 1'b0;
  logic [31:0]  tgt;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic sb_observe();
    fetch_entry_t e;
    if (redirect) begin
      chk("req_in_redirect", imem_req, 0);
      exp_q.delete();
    end else if (instr_valid && instr_ready) begin
      chk("pop_underflow", (exp_q.size() == 0), 0);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_instr", instr, e.instr);
        npop++;
      end
    end
    if (imem_req && imem_gnt) begin
      exp_q.push_back('{pc: imem_addr, instr: memf(imem_addr)});
      pend.push_back(imem_addr);
      glog.push_back(imem_addr);
    end
  endtask

  task automatic mem_drive();
    logic [31:0] a;
    imem_rvalid = 1'b0;
    if (!mem_hold && pend.size() != 0) begin
      a = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = memf(a);
    end
  endtask

  // Observe, clock, drive memory, and return parked at the next negedge.
  task automatic tick();
    #1;
    sb_observe();
    @(posedge clk);
    #1;
    mem_drive();
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    imem_gnt = 1'b0;
    instr_ready = 1'b1;
    while ((exp_q.size() != 0 || pend.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk("drain", exp_q.size() + pend.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_err", fetch_err, 0);
    chk("rst_addr", imem_addr, 32'hBFC0_0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch after reset
    imem_gnt = 1'b1;
    instr_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k < 2) chk("t1_no_valid", instr_valid, 0);
      if (k == 2) begin
        chk("t1_first_valid", instr_valid, 1);
        chk("t1_first_pc", instr_pc, 32'hBFC0_0000);
      end
      tick();
    end
    chk("t1_a0", glog[0], 32'hBFC0_0000);
    chk("t1_a1", glog[1], 32'hBFC0_0004);
    chk("t1_a2", glog[2], 32'hBFC0_0008);
    drain();

    // Credit limit while decode stalls
    glog.delete();
    instr_ready = 1'b0;
    imem_gnt = 1'b1;
    repeat (6) tick();
    chk("t2_grants", glog.size(), 2);
    #1;
    chk("t2_req_full", imem_req, 0);
    instr_ready = 1'b1;
    #1;
    chk("t2_req_pop", imem_req, 0);
    tick();
    #1;
    chk("t2_reissue", imem_req, 1);
    drain();

    // Redirect with two requests outstanding
    mem_hold = 1'b1;
    imem_gnt = 1'b1;
    tick();
    tick();
    #1;
    chk("t3_req_credit", imem_req, 0);
    redirect = 1'b1;
    pc_next = 32'h0040_0020;
    tick();
    redirect = 1'b0;
    mem_hold = 1'b0;
    #1;
    chk("t3_addr", imem_addr, 32'h0040_0020);
    chk("t3_err", fetch_err, 0);
    begin
      int n = 0;
      while (!instr_valid && n < 20) begin
        tick();
        n++;
      end
    end
    chk("t3_valid", instr_valid, 1);
    chk("t3_first_pc", instr_pc, 32'h0040_0020);
    drain();

    // Misaligned redirect target
    redirect = 1'b1;
    pc_next = 32'h0040_0022;
    tick();
    redirect = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    #1;
    chk("t4_err", fetch_err, 1);
    chk("t4_noreq", imem_req, 0);
    repeat (3) tick();
    chk("t4_err_held", fetch_err, 1);
    chk("t4_noreq_held", imem_req, 0);
    redirect = 1'b1;
    pc_next = 32'h0040_0024;
    #1;
    chk("t4_err_clear", fetch_err, 0);
    tick();
    redirect = 1'b0;
    tgt = 32'h0040_0024;
`else
    tgt = 32'h0040_0020;
    #1;
    chk("t4_err_tied", fetch_err, 0);
`endif
    chk("t4_addr", imem_addr, tgt);
    chk("t4_req", imem_req, 1);

    // Grant withheld: request and address hold steady
    imem_gnt = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t5_req_hold", imem_req, 1);
      chk("t5_addr_hold", imem_addr, tgt);
      tick();
    end
    glog.delete();
    imem_gnt = 1'b1;
    tick();
    chk("t5_grant_addr", glog[0], tgt);
    drain();

    // Redirect coinciding with a response and a pop
    glog.delete();
    imem_gnt = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("t6_pre_valid", instr_valid, 1);
    redirect = 1'b1;
    pc_next = 32'h0000_1000;
    instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    chk("t6_flushed", instr_valid, 0);
    glog.delete();
    repeat (4) tick();
    chk("t6_resume", glog[0], 32'h0000_1000);
    drain();

    // PC wrap at the top of the address space
    redirect = 1'b1;
    pc_next = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    glog.delete();
    imem_gnt = 1'b1;
    repeat (4) tick();
    chk("t7_top", glog[0], 32'hFFFF_FFFC);
    chk("t7_wrap", glog[1], 32'h0000_0000);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    chk("sb_pops", (npop >= 8), 1);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
